div_unit: RTL and testbench

Sequential 32-bit integer divider for the CPU's multiply/divide path: the inverse of the ALU's add/subtract datapath, built from repeated trial subtraction. Accepts a dividend/divisor pair on a start pulse, runs a restoring-division loop one bit per cycle, and returns quotient and remainder with a one-cycle done pulse. The execute stage stalls on `busy` and writes `quo`/`rem` into LO/HI when `done` is seen.

---
 rtl/div_pkg.sv | 6 +
 rtl/div_step.sv | 20 ++
 rtl/div_unit.sv | 108 ++++++++++
 tb/tb_div_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared width constants and FSM state type for the sequential divider.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 5;
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step (shift in a bit, trial-subtract).
module div_step
    import div_pkg::*;
#(
    parameter int W = DIV_WIDTH
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_dvs,
    output logic [W-1:0] o_rem,
    output logic         o_q
);
    logic [W:0] w_shift;
    logic [W:0] w_diff;
    assign w_shift = {i_rem, i_bit};
    // The shifted remainder stays below 2*divisor, so bit W of the difference is a clean borrow.
    assign w_diff  = w_shift - {1'b0, i_dvs};
    assign o_q     = ~w_diff[W];
    assign o_rem   = o_q ? w_diff[W-1:0] : w_shift[W-1:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: 32-bit sequential restoring divider, one quotient bit per cycle, signed/unsigned.
// DIV_ZERO_DETECT_EN short-circuits a zero divisor straight to FIX and raises dz.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             dz
);
    state_t               r_state;
    logic [DIV_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]     r_dvd;
    logic [WIDTH-1:0]     r_dvs;
    logic [WIDTH-1:0]     r_rem;
    logic                 r_qs;
    logic                 r_rs;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH-1:0]     w_rem;
    logic                 w_q;
`ifdef DIV_ZERO_DETECT_EN
    logic                 r_dzp;
`else
    assign dz = 1'b0;
`endif
    assign w_a_mag = (Sign && A[WIDTH-1]) ? -A : A;
    assign w_b_mag = (Sign && B[WIDTH-1]) ? -B : B;
    // r_dvd doubles as dividend shifter and quotient accumulator.
    div_step #(.W(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_bit (r_dvd[WIDTH-1]),
        .i_dvs (r_dvs),
        .o_rem (w_rem),
        .o_q   (w_q)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_qs    <= 1'b0;
            r_rs    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            quo     <= '0;
            rem     <= '0;
`ifdef DIV_ZERO_DETECT_EN
            r_dzp   <= 1'b0;
            dz      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    busy    <= 1'b1;
                    r_rem   <= '0;
                    r_dvd   <= w_a_mag;
                    r_dvs   <= w_b_mag;
                    r_qs    <= Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                    r_rs    <= Sign & A[WIDTH-1];
                    r_cnt   <= DIV_CNT_W'(WIDTH - 1);
                    r_state <= CALC;
`ifdef DIV_ZERO_DETECT_EN
                    r_dzp   <= (B == '0);
                    if (B == '0) begin
                        r_rem   <= A;
                        r_dvd   <= '1;
                        r_qs    <= 1'b0;
                        r_rs    <= 1'b0;
                        r_state <= FIX;
                    end
`endif
                end
                CALC: begin
                    r_rem <= w_rem;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_q};
                    if (r_cnt == '0)
                        r_state <= FIX;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                FIX: begin
                    quo     <= r_qs ? -r_dvd : r_dvd;
                    rem     <= r_rs ? -r_rem : r_rem;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= IDLE;
`ifdef DIV_ZERO_DETECT_EN
                    dz      <= r_dzp;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit; expected results queued at acceptance, popped on done.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] quo;
    logic [31:0] rem;
`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_unexp = 0;
    int   n_overlap = 0;
    div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Sign  (sgn),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .quo   (quo),
        .rem   (rem),
        .dz    (dz)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && done) n_overlap++;
            if (done) begin
                if (sb.size() == 0) n_unexp++;
                else begin
                    mon_e = sb.pop_front();
                    check("quo", quo, mon_e.q);
                    check("rem", rem, mon_e.r);
                    check("dz", {31'b0, dz}, {31'b0, mon_e.dz});
                    check("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                end
            end
        end
    end
    function automatic void model(input logic s, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r);
        if (y == 0) begin
            q = (!DZ && s && x[31]) ? 32'h1 : 32'hFFFF_FFFF;
            r = x;
        end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = x;
            r = '0;
        end else if (s) begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction
    task automatic go(input logic s, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] q, input logic [31:0] r);
        exp_t e;
        sgn = s;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        sgn = ~sgn;
        e.q = q;
        e.r = r;
        e.dz = DZ && (y == 0);
        e.lat = (DZ && y == 0) ? 1 : 33;
        e.acc = cyc;
        sb.push_back(e);
        check("busy_acc", {31'b0, busy}, 32'd1);
    endtask
    task automatic wait_done();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask
    initial begin
        logic [31:0] rq, rr, ra, rb;
        logic        rs;
        repeat (2) @(posedge clk);
        #1;
        check("rst_quo", quo, 32'd0);
        check("rst_rem", rem, 32'd0);
        check("rst_flags", {29'b0, busy, done, dz}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        go(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);                         wait_done();
        go(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);     wait_done();
        go(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);             wait_done();
        go(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);     wait_done();
        go(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);             wait_done();
        go(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1);             wait_done();
        go(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);                     wait_done();
        go(1'b1, 32'hFFFF_FFFB, 32'd0, DZ ? 32'hFFFF_FFFF : 32'd1, 32'hFFFF_FFFB); wait_done();
        for (int i = 0; i < 8; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (rb == 0) rb = 32'd3;
            model(rs, ra, rb, rq, rr);
            go(rs, ra, rb, rq, rr);
            wait_done();
        end
        go(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        repeat (5) @(posedge clk);
        #1;
        sgn = 1'b1;
        a = 32'd55;
        b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        go(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1;
        end
        check("b2b_done", {31'b0, done}, 32'd1);
        go(1'b0, 32'd200, 32'd9, 32'd22, 32'd2);
        wait_done();
        go(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_quo", quo, 32'd0);
        check("midrst_rem", rem, 32'd0);
        check("midrst_flags", {29'b0, busy, done, dz}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        go(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        wait_done();
        check("unexpected_done", 32'(n_unexp), 32'd0);
        check("busy_done_overlap", 32'(n_overlap), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
